// File: rtl/matrix_stream_flattener.sv
// Reads an N x N matrix one row per cycle from a synchronous memory and presents
// it as one flat word, row-major or column-major, behind a valid/ready handshake.
module matrix_stream_flattener #(
  parameter  int MATRIX_SIZE = 4,
  parameter  int DATA_WIDTH  = 8,
  parameter  int RD_LATENCY  = 1,
  localparam int ADDR_WIDTH  = ($clog2(MATRIX_SIZE) < 1) ? 1 : $clog2(MATRIX_SIZE)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        transpose,
  input  logic                                        abort,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0]           mem_rdata,
  output logic                                        mem_en,
  output logic                                        mem_we,
  output logic [ADDR_WIDTH-1:0]                       mem_addr,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] flat_out,
  output logic                                        flat_valid,
  input  logic                                        flat_ready,
  output logic                                        busy,
  output logic                                        done
);

  localparam int N      = MATRIX_SIZE;
  localparam int DW     = DATA_WIDTH;
  localparam int L      = RD_LATENCY;
  localparam int ROW_W  = N * DW;
  localparam int FLAT_W = N * N * DW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] row_cnt_q;
  logic                  vld_q [L];
  logic [ADDR_WIDTH-1:0] idx_q [L];
  logic [ROW_W-1:0]      rows_q [N];
  logic [ROW_W-1:0]      rows_d [N];
  logic [FLAT_W-1:0]     flat_q;
  logic [FLAT_W-1:0]     flat_rm;
  logic [FLAT_W-1:0]     flat_cm;

  logic abort_act;
  logic cap_en;
  logic last_cap;
  logic last_read;

  assign abort_act = abort && (state_q == S_READ || state_q == S_DRAIN || state_q == S_PRESENT);
  assign cap_en    = vld_q[L-1] && !abort_act;
  assign last_cap  = cap_en && (idx_q[L-1] == ADDR_WIDTH'(N - 1));
  assign last_read = (row_cnt_q == ADDR_WIDTH'(N - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks every other transition out of a busy state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_READ;
      S_READ:    if (abort) state_d = S_IDLE;
                 else if (last_read) state_d = S_DRAIN;
      S_DRAIN:   if (abort) state_d = S_IDLE;
                 else if (last_cap) state_d = S_PRESENT;
      S_PRESENT: if (abort) state_d = S_IDLE;
                 else if (flat_ready) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_en     = (state_q == S_READ);
    mem_we     = 1'b0;
    mem_addr   = (state_q == S_READ) ? row_cnt_q : '0;
    flat_valid = (state_q == S_PRESENT);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    flat_out   = flat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      row_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        row_cnt_q <= '0;
        if (start) mode_q <= transpose;
      end else if (state_q == S_READ) begin
        row_cnt_q <= row_cnt_q + 1'b1;
      end
    end
  end

  // Tracks which row each outstanding read returns; stage L-1 lines up with mem_rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        vld_q[i] <= 1'b0;
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= (state_q == S_READ) && !abort;
      idx_q[0] <= row_cnt_q;
      for (int i = 1; i < L; i++) begin
        vld_q[i] <= vld_q[i-1] && !abort_act;
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  genvar gi, gc;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      assign rows_d[gi] = (cap_en && idx_q[L-1] == ADDR_WIDTH'(gi)) ? mem_rdata : rows_q[gi];

      // Column c of a row sits at bits (N-1-c)*DW; flat index 0 lands in the MSBs
      for (gc = 0; gc < N; gc++) begin : g_col
        assign flat_rm[(N*N-1-(gi*N+gc))*DW +: DW] = rows_d[gi][(N-1-gc)*DW +: DW];
        assign flat_cm[(N*N-1-(gc*N+gi))*DW +: DW] = rows_d[gi][(N-1-gc)*DW +: DW];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        rows_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        rows_q[i] <= rows_d[i];
      end
    end
  end

  // The output word only changes on the edge that enters PRESENT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flat_q <= '0;
    end else if (state_q == S_DRAIN && last_cap) begin
      flat_q <= mode_q ? flat_cm : flat_rm;
    end
  end

endmodule

// File: tb/tb_matrix_stream_flattener.sv
// Directed bench: one flattener with read latency 1 and one with latency 3, each
// fed by a small behavioural memory of the matching latency.
module tb_matrix_stream_flattener;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, transpose, abort, ready, sel;
  logic         start1, start3, abort1, abort3;
  logic [31:0]  rd1, rd3, p0, p1;
  logic [31:0]  mem [4];
  logic         en1, we1, fv1, busy1, done1;
  logic         en3, we3, fv3, busy3, done3;
  logic [1:0]   addr1, addr3;
  logic [127:0] flat1, flat3;

  logic [127:0] fo;
  logic         fv, bsy, dn, en;
  logic [1:0]   ad;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  localparam logic [127:0] A_RM = 128'h00010203_10111213_20212223_30313233;
  localparam logic [127:0] A_CM = 128'h00102030_01112131_02122232_03132333;
  localparam logic [127:0] B_RM = 128'h40414243_50515253_60616263_70717273;

  assign start1 = start && !sel;
  assign start3 = start && sel;
  assign abort1 = abort && !sel;
  assign abort3 = abort && sel;
  assign fo  = sel ? flat3 : flat1;
  assign fv  = sel ? fv3   : fv1;
  assign bsy = sel ? busy3 : busy1;
  assign dn  = sel ? done3 : done1;
  assign en  = sel ? en3   : en1;
  assign ad  = sel ? addr3 : addr1;

  matrix_stream_flattener #(.MATRIX_SIZE(4), .DATA_WIDTH(8), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .transpose(transpose), .abort(abort1),
    .mem_rdata(rd1), .mem_en(en1), .mem_we(we1), .mem_addr(addr1),
    .flat_out(flat1), .flat_valid(fv1), .flat_ready(ready), .busy(busy1), .done(done1)
  );

  matrix_stream_flattener #(.MATRIX_SIZE(4), .DATA_WIDTH(8), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .transpose(transpose), .abort(abort3),
    .mem_rdata(rd3), .mem_en(en3), .mem_we(we3), .mem_addr(addr3),
    .flat_out(flat3), .flat_valid(fv3), .flat_ready(ready), .busy(busy3), .done(done3)
  );

  always @(posedge clk) begin
    rd1 <= en1 ? mem[addr1] : 32'h0;
    p0  <= en3 ? mem[addr3] : 32'h0;
    p1  <= p0;
    rd3 <= p1;
  end

  task automatic set_mem(input logic [7:0] base);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        mem[k][(3-j)*8 +: 8] = base + 8'(16*k + j);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (fv !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("valid_seen", 128'(fv), 128'(1));
  endtask

  // One conversion with ready held high, checking addresses, latency and data
  task automatic conv(input string tag, input logic tr, input logic [127:0] exp);
    cyc = 0;
    transpose = tr;
    start = 1'b1;
    step();
    start = 1'b0;
    transpose = ~tr;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_mem_en"}, 128'(en), 128'(1));
      chk({tag, "_addr"}, 128'(ad), 128'(k));
      if (k < 3) step();
    end
    wait_valid();
    chk({tag, "_valid_cycle"}, 128'(cyc), sel ? 128'(8) : 128'(6));
    chk({tag, "_flat"}, fo, exp);
    step();
    chk({tag, "_done"}, 128'(dn), 128'(1));
    chk({tag, "_valid_off"}, 128'(fv), 128'(0));
    step();
    chk({tag, "_done_off"}, 128'(dn), 128'(0));
    chk({tag, "_idle"}, 128'(bsy), 128'(0));
    chk({tag, "_flat_hold"}, fo, exp);
  endtask

  initial begin
    sel = 1'b0; rst = 1'b0; start = 1'b0; transpose = 1'b0; abort = 1'b0; ready = 1'b1;
    set_mem(8'h00);
    #1 rst = 1'b1;
    #2;
    chk("rst_flat1", flat1, 128'h0);
    chk("rst_flat3", flat3, 128'h0);
    chk("rst_ctrl1", {122'h0, en1, we1, fv1, busy1, done1, |addr1}, 128'h0);
    chk("rst_ctrl3", {122'h0, en3, we3, fv3, busy3, done3, |addr3}, 128'h0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", 128'(busy1), 128'(0));

    // Row-major then column-major, latency 1
    conv("rm_l1", 1'b0, A_RM);
    conv("cm_l1", 1'b1, A_CM);

    // Latency 3 with a five-cycle consumer stall
    sel = 1'b1;
    ready = 1'b0;
    cyc = 0;
    transpose = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid();
    chk("l3_valid_cycle", 128'(cyc), 128'(8));
    chk("l3_flat", fo, A_RM);
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", 128'(fv), 128'(1));
      chk("stall_flat", fo, A_RM);
      chk("stall_no_done", 128'(dn), 128'(0));
      step();
    end
    chk("stall_end_valid", 128'(fv), 128'(1));
    ready = 1'b1;
    step();
    chk("l3_done", 128'(dn), 128'(1));
    step();
    chk("l3_done_once", 128'(dn), 128'(0));
    chk("l3_flat_hold", fo, A_RM);
    sel = 1'b0;

    // Abort in the third READ cycle, then rerun on new memory contents
    cyc = 0;
    transpose = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("abort_in_read", 128'(en), 128'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", 128'(bsy), 128'(0));
    chk("abort_no_done", 128'(dn), 128'(0));
    chk("abort_mem_en", 128'(en), 128'(0));
    chk("abort_flat_kept", fo, A_CM);
    step();
    chk("abort_no_done2", 128'(dn), 128'(0));
    chk("abort_no_valid", 128'(fv), 128'(0));
    set_mem(8'h40);
    conv("after_abort", 1'b0, B_RM);

    // Reset pulse while draining
    set_mem(8'h00);
    cyc = 0;
    transpose = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("drain_busy", 128'(bsy), 128'(1));
    chk("drain_mem_en", 128'(en), 128'(0));
    rst = 1'b1;
    #1;
    chk("rst_mid_flat", fo, 128'h0);
    chk("rst_mid_ctrl", {123'h0, en, fv, bsy, dn, |ad}, 128'h0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("rst_mid_stays_idle", 128'(bsy), 128'(0));
    conv("after_rst", 1'b0, A_RM);

    // Start held high: two runs, second one picks up the later transpose
    cyc = 0;
    transpose = 1'b0;
    start = 1'b1;
    step();
    transpose = 1'b1;
    wait_valid();
    chk("b2b1_valid_cycle", 128'(cyc), 128'(6));
    chk("b2b1_flat", fo, A_RM);
    step();
    chk("b2b1_done", 128'(dn), 128'(1));
    step();
    chk("b2b_gap_idle", 128'(bsy), 128'(0));
    wait_valid();
    chk("b2b2_valid_cycle", 128'(cyc), 128'(14));
    chk("b2b2_flat", fo, A_CM);
    step();
    chk("b2b2_done", 128'(dn), 128'(1));
    start = 1'b0;
    step();
    chk("b2b_end_idle", 128'(bsy), 128'(0));
    step();
    chk("b2b_no_third", 128'(bsy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_stream_flattener.md
MATRIX_STREAM_FLATTENER -- requirements
Module: matrix_stream_flattener

Interface
REQ-001 SHALL have parameter MATRIX_SIZE, default 4: matrix order N, legal range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: element width DW in bits.
REQ-003 SHALL have parameter RD_LATENCY, default 1: memory read latency L in cycles, legal range 1..3.
REQ-004 SHALL have localparam ADDR_WIDTH = max(1, clog2(N)).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  request one conversion; sampled only in IDLE.
REQ-008 transpose  input  1  0 = row-major output, 1 = column-major output; sampled with start.
REQ-009 abort  input  1  synchronous cancel of a conversion in progress.
REQ-010 mem_rdata  input  N*DW  one matrix row; column 0 in the MSBs.
REQ-011 mem_en  output  1  memory enable.
REQ-012 mem_we  output  1  memory write enable; tied 0.
REQ-013 mem_addr  output  ADDR_WIDTH  row address.
REQ-014 flat_out  output  N*N*DW  flattened matrix.
REQ-015 flat_valid  output  1  flat_out is valid.
REQ-016 flat_ready  input  1  consumer accepts flat_out.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  single-cycle completion pulse.

Function
REQ-019 SHALL implement the states IDLE, READ, DRAIN, PRESENT and DONE.
REQ-020 IDLE: start=1 at a rising edge SHALL capture transpose into mode_q, clear the row counter, and move to READ.
REQ-021 READ: SHALL drive mem_en=1 and mem_addr=k in the k-th READ cycle (k=0..N-1), one row per cycle with no gaps; after the N-1 cycle SHALL move to DRAIN.
REQ-022 mem_en SHALL be 0 in every state other than READ.
REQ-023 A row addressed in cycle t SHALL be captured from mem_rdata at the edge ending cycle t+L into row buffer slot k; capture SHALL use an L-deep valid/index shift pipeline.
REQ-024 DRAIN: when the final row (slot N-1) is captured, SHALL load flat_out and move to PRESENT.
REQ-025 Packing: element (r,c) is bits [(N-1-c)*DW +: DW] of row r; output index i = r*N+c when mode_q=0 and i = c*N+r when mode_q=1; element i occupies flat_out[(N*N-1-i)*DW +: DW], so index 0 is in the MSBs.
REQ-026 PRESENT: flat_valid SHALL be 1; flat_out SHALL be held stable until flat_valid=1 and flat_ready=1 at the same edge, then the block SHALL move to DONE.
REQ-027 DONE: done=1 for exactly one cycle, then the block SHALL return to IDLE; a start sampled in that IDLE cycle SHALL begin a new conversion.
REQ-028 Latency: with start sampled at the edge ending cycle 0 and flat_ready held 1, flat_valid SHALL be 1 in cycle N+L+1 and done SHALL be 1 in cycle N+L+2.
REQ-029 flat_out SHALL keep its last loaded value after the handshake and SHALL change only on entry to PRESENT.
REQ-030 start while busy=1 SHALL be ignored and not queued; transpose changes while busy=1 SHALL be ignored.
REQ-031 abort=1 in READ, DRAIN or PRESENT SHALL return the block to IDLE at the next edge: no done pulse, flat_out unchanged, and in-flight reads discarded.
REQ-032 abort SHALL take priority over a simultaneous flat_ready handshake; abort in IDLE or DONE SHALL have no effect.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE, mem_en=0, mem_we=0, mem_addr=0, flat_out=0, flat_valid=0, busy=0, done=0, mode_q=0, clear the row buffer, and clear the capture pipeline.
REQ-034 Assertion of rst mid-operation SHALL abandon the conversion; after release the block SHALL start only on a new start.

Verification
REQ-035 N=4, DW=8, L=1, row k = 0x{k}0{k}1{k}2{k}3, transpose=0, ready=1 -> flat_out=0x00010203_10111213_20212223_30313233, valid in cycle 6, done in cycle 7.
REQ-036 Same data with transpose=1 -> flat_out=0x00102030_01112131_02122232_03132333.
REQ-037 L=3 with flat_ready held 0 for 5 cycles after valid -> flat_out stable throughout the stall, valid first in cycle 8, exactly one done pulse after ready rises.
REQ-038 abort asserted in the 3rd READ cycle, then start -> no done from the first run, second run completes with correct data, and late rows from the first run are not captured.
REQ-039 rst pulsed during DRAIN -> all outputs read 0 during reset; a subsequent start completes normally.
REQ-040 Back-to-back: start held high continuously -> consecutive conversions, each producing one done pulse, with the sampled transpose honoured per run.
